// File: rtl/display_pkg.sv
// Shared types for the display mode sequencer: mux select encoding, blank FSM
// states and a helper that sizes counters from their terminal count.
package display_pkg;

   typedef enum logic [1:0] {
      MODE_AVG   = 2'b00,
      MODE_VOLT  = 2'b01,
      MODE_RAW   = 2'b10,
      MODE_SPARE = 2'b11
   } display_mode_t;

   typedef enum logic {
      SHOW  = 1'b0,
      BLANK = 1'b1
   } blank_state_t;

   // Counter width able to hold 0..n-1; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/button_debounce.sv
// Raw push-button conditioning: 2-flop synchronizer, stable-level debouncer,
// and a one-cycle pulse on each rising edge of the debounced level.
module button_debounce
   import display_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic rise
);

   localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic          state;
   logic [CW-1:0] cnt;
   logic          differ;
   logic          flip;

   // The debounced level flips on the DEBOUNCE_CYCLES-th consecutive cycle
   // in which the synchronized input disagrees with it.
   assign differ = (sync2 != state);
   assign flip   = differ && (cnt == CNT_LAST);

   // Synchronizer, disagreement counter, debounced level and rise pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         state <= 1'b0;
         cnt   <= '0;
         rise  <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         rise  <= flip && !state;
         if (!differ) begin
            cnt <= '0;
         end else if (flip) begin
            cnt   <= '0;
            state <= ~state;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/display_mode_sequencer.sv
// Steps the 4-way display mux select from debounced next/prev buttons or an
// auto-scroll dwell timer, and opens a blanking window after every change so
// the seven-segment driver can hide ghosting while the mux output settles.
module display_mode_sequencer
   import display_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned DWELL_CYCLES    = 200_000_000,
   parameter int unsigned BLANK_CYCLES    = 100_000
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          btn_next,
   input  logic          btn_prev,
   input  logic          auto_en,
   input  logic          freeze,
   output display_mode_t select,
   output logic          mode_change,
   output logic          blank
);

   localparam int unsigned DW = cnt_width(DWELL_CYCLES);
   localparam int unsigned BW = cnt_width(BLANK_CYCLES);
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
   localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

   logic          next_req;
   logic          prev_req;
   logic          change;
   display_mode_t sel_next;
   logic [DW-1:0] dwell;
   logic [DW-1:0] dwell_next;
   blank_state_t  state;
   blank_state_t  state_next;
   logic [BW-1:0] bcnt;
   logic [BW-1:0] bcnt_next;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_next),
      .rise  (next_req)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_prev),
      .rise  (prev_req)
   );

   // Step resolution: freeze wins, then conflicting buttons cancel, then a
   // manual step, and only with no manual request does a dwell expiry step.
   always_comb begin
      sel_next = select;
      change   = 1'b0;
      if (!freeze) begin
         if (next_req && prev_req) begin
            change = 1'b0;
         end else if (next_req) begin
            sel_next = display_mode_t'(select + 2'd1);
            change   = 1'b1;
         end else if (prev_req) begin
            sel_next = display_mode_t'(select - 2'd1);
            change   = 1'b1;
         end else if (auto_en && (dwell == DWELL_LAST)) begin
            sel_next = display_mode_t'(select + 2'd1);
            change   = 1'b1;
         end
      end
   end

   // Dwell timer: idle at 0 without auto_en, frozen by freeze, restarted by
   // any select change so each mode gets a full dwell period.
   always_comb begin
      dwell_next = dwell;
      if (!auto_en) begin
         dwell_next = '0;
      end else if (freeze) begin
         dwell_next = dwell;
      end else if (change) begin
         dwell_next = '0;
      end else begin
         dwell_next = dwell + DW'(1);
      end
   end

   // Select, dwell timer and the one-cycle change pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         select      <= MODE_AVG;
         dwell       <= '0;
         mode_change <= 1'b0;
      end else begin
         select      <= sel_next;
         dwell       <= dwell_next;
         mode_change <= change;
      end
   end

   // Blank FSM next state: every change (re)starts a full window.
   always_comb begin
      state_next = state;
      bcnt_next  = bcnt;
      if (change) begin
         state_next = BLANK;
         bcnt_next  = '0;
      end else if (state == BLANK) begin
         if (bcnt == BLANK_LAST) begin
            state_next = SHOW;
            bcnt_next  = '0;
         end else begin
            bcnt_next = bcnt + BW'(1);
         end
      end
   end

   // Blank FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= SHOW;
         bcnt  <= '0;
      end else begin
         state <= state_next;
         bcnt  <= bcnt_next;
      end
   end

   assign blank = (state == BLANK);

endmodule

// File: tb/tb_display_mode_sequencer.sv
// Directed bench for display_mode_sequencer with short debounce, dwell and
// blank periods so every timing corner fits in a few hundred cycles.
module tb_display_mode_sequencer;
   import display_pkg::*;

   localparam int unsigned DEB   = 4;
   localparam int unsigned DWELL = 10;
   localparam int unsigned BLK   = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          btn_next;
   logic          btn_prev;
   logic          auto_en;
   logic          freeze;
   display_mode_t select;
   logic          mode_change;
   logic          blank;

   int n_pass  = 0;
   int n_total = 0;

   logic [1:0] exp_q[$];

   typedef struct {
      logic       rst;
      logic       nxt;
      logic       prv;
      logic       aut;
      logic       frz;
      logic [1:0] sel;
      logic       mc;
      logic       bl;
   } vec_t;

   vec_t vecs[$];

   display_mode_sequencer #(
      .DEBOUNCE_CYCLES (DEB),
      .DWELL_CYCLES    (DWELL),
      .BLANK_CYCLES    (BLK)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .btn_next    (btn_next),
      .btn_prev    (btn_prev),
      .auto_en     (auto_en),
      .freeze      (freeze),
      .select      (select),
      .mode_change (mode_change),
      .blank       (blank)
   );

   // Clock.
   always #5 clk = ~clk;

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [1:0] es, input logic em, input logic eb);
      n_total++;
      if (select === es && mode_change === em && blank === eb) n_pass++;
      else $display("FAIL %s: got select=%b mode_change=%b blank=%b, want select=%b mode_change=%b blank=%b",
                    name, select, mode_change, blank, es, em, eb);
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, want %0d", name, act, exp);
   endtask

   // Tick and score every observed mode change against the expected queue.
   task automatic tick_sb();
      logic [1:0] e;
      tick();
      if (mode_change === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL sb_unexpected: got select=%b, want no change", select);
         end else begin
            e = exp_q.pop_front();
            check("sb_step", e, 1'b1, 1'b1);
         end
      end
   endtask

   task automatic press_sb(input logic is_next);
      if (is_next) btn_next = 1'b1; else btn_prev = 1'b1;
      repeat (8) tick_sb();
      btn_next = 1'b0;
      btn_prev = 1'b0;
      repeat (8) tick_sb();
   endtask

   task automatic add_vec(input logic r, input logic n, input logic p, input logic a, input logic f,
                          input logic [1:0] s, input logic m, input logic b);
      vec_t v;
      v.rst = r; v.nxt = n; v.prv = p; v.aut = a; v.frz = f;
      v.sel = s; v.mc = m; v.bl = b;
      vecs.push_back(v);
   endtask

   initial begin
      int pulses;
      int k;
      int last;
      logic [1:0] es;
      logic em;
      logic eb;
      int chg[8];
      chg = '{10, 20, 30, 40, 50, 60, 65, 75};

      reset = 1'b1; btn_next = 1'b0; btn_prev = 1'b0; auto_en = 1'b0; freeze = 1'b0;

      // Test 1: reset, then btn_next held 20 cycles and released.
      add_vec(1, 0, 0, 0, 0, 2'd0, 0, 0);
      add_vec(1, 0, 0, 0, 0, 2'd0, 0, 0);
      for (int i = 1; i <= 6; i++) add_vec(0, 1, 0, 0, 0, 2'd0, 0, 0);
      add_vec(0, 1, 0, 0, 0, 2'd1, 1, 1);
      add_vec(0, 1, 0, 0, 0, 2'd1, 0, 1);
      add_vec(0, 1, 0, 0, 0, 2'd1, 0, 1);
      for (int i = 10; i <= 20; i++) add_vec(0, 1, 0, 0, 0, 2'd1, 0, 0);
      for (int i = 0; i < 10; i++) add_vec(0, 0, 0, 0, 0, 2'd1, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         reset = vecs[i].rst; btn_next = vecs[i].nxt; btn_prev = vecs[i].prv;
         auto_en = vecs[i].aut; freeze = vecs[i].frz;
         tick();
         check($sformatf("vec%0d", i), vecs[i].sel, vecs[i].mc, vecs[i].bl);
      end

      // Test 2: bouncing press, high 3 / low 1 / high held.
      pulses = 0;
      for (int i = 1; i <= 34; i++) begin
         btn_next = (i <= 3) || (i >= 5 && i <= 20);
         tick();
         if (mode_change === 1'b1) pulses++;
         if (i == 10) check("bounce_hold", 2'd1, 1'b0, 1'b0);
         if (i == 11) check("bounce_step", 2'd2, 1'b1, 1'b1);
      end
      check_int("bounce_pulses", pulses, 1);
      check("bounce_final", 2'd2, 1'b0, 1'b0);

      // Test 3: reset, then four prev presses wrap 00 -> 11 -> 10 -> 01 -> 00.
      reset = 1'b1;
      tick();
      tick();
      check("reset_state", 2'd0, 1'b0, 1'b0);
      reset = 1'b0;
      exp_q.push_back(2'd3);
      exp_q.push_back(2'd2);
      exp_q.push_back(2'd1);
      exp_q.push_back(2'd0);
      for (int i = 0; i < 4; i++) press_sb(1'b0);
      check_int("sb_drained", exp_q.size(), 0);
      check("prev_final", 2'd0, 1'b0, 1'b0);

      // Test 4: auto-scroll, manual step on a dwell expiry, manual restart of dwell.
      k = 0;
      last = -100;
      es = 2'd0;
      for (int i = 1; i <= 80; i++) begin
         auto_en  = 1'b1;
         btn_next = (i >= 44 && i <= 51) || (i >= 59 && i <= 66);
         tick();
         em = 1'b0;
         if (k < 8 && i == chg[k]) begin
            em = 1'b1;
            es = es + 2'd1;
            last = i;
            k++;
         end
         eb = (i - last) < int'(BLK);
         check($sformatf("auto_t%0d", i), es, em, eb);
      end
      auto_en  = 1'b0;
      btn_next = 1'b0;
      repeat (10) tick();

      // Test 5: freeze discards presses and dwell expiries.
      pulses = 0;
      freeze = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         auto_en  = 1'b1;
         btn_next = (i >= 2 && i <= 9) || (i >= 25 && i <= 32);
         btn_prev = (i >= 12 && i <= 19) || (i >= 25 && i <= 32);
         tick();
         if (mode_change === 1'b1) pulses++;
      end
      check_int("freeze_pulses", pulses, 0);
      check("freeze_final", 2'd0, 1'b0, 1'b0);
      freeze   = 1'b0;
      auto_en  = 1'b0;
      btn_next = 1'b0;
      btn_prev = 1'b0;
      tick();

      // Simultaneous next+prev with freeze low cancel each other.
      pulses = 0;
      for (int i = 1; i <= 20; i++) begin
         btn_next = (i <= 8);
         btn_prev = (i <= 8);
         tick();
         if (mode_change === 1'b1) pulses++;
      end
      check_int("both_pulses", pulses, 0);
      check("both_final", 2'd0, 1'b0, 1'b0);

      // Test 6a: second step one cycle into the blank window extends it.
      for (int i = 1; i <= 20; i++) begin
         btn_next = (i <= 8);
         btn_prev = (i >= 2 && i <= 8);
         tick();
         if (i == 7)  check("ext_first",  2'd1, 1'b1, 1'b1);
         if (i == 8)  check("ext_second", 2'd0, 1'b1, 1'b1);
         if (i == 9)  check("ext_b1",     2'd0, 1'b0, 1'b1);
         if (i == 10) check("ext_b2",     2'd0, 1'b0, 1'b1);
         if (i == 11) check("ext_end",    2'd0, 1'b0, 1'b0);
      end

      // Test 6b: reset one cycle into a blank window aborts it.
      for (int i = 1; i <= 9; i++) begin
         btn_prev = (i <= 7);
         reset    = (i == 9);
         tick();
         if (i == 7) check("rb_step",  2'd3, 1'b1, 1'b1);
         if (i == 8) check("rb_mid",   2'd3, 1'b0, 1'b1);
         if (i == 9) check("rb_reset", 2'd0, 1'b0, 1'b0);
      end
      reset  = 1'b0;
      pulses = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (mode_change === 1'b1) pulses++;
      end
      check_int("rb_quiet", pulses, 0);
      check("rb_final", 2'd0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/display_mode_sequencer.md
# display_mode_sequencer

Sequences the `select` input of the 4-way 16-bit display mux that feeds the seven-segment driver. It chooses one of the four display sources: averaged ADC, scaled voltage, raw ADC, or spare.
- Manual stepping uses two debounced push-buttons (next/prev).
- An optional auto-scroll mode advances on a dwell timer.
- A freeze input holds the current mode.
- After each mode change the block issues a short blanking window so the display driver can suppress digit ghosting while the mux output and decimal point settle.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required to accept a button level (10 ms at 100 MHz); minimum 2
- DWELL_CYCLES, 200_000_000, auto-scroll period per mode (2 s at 100 MHz); minimum 2
- BLANK_CYCLES, 100_000, length of the blank window after a mode change; minimum 1

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- btn_next  in  1  raw asynchronous button, step forward
- btn_prev  in  1  raw asynchronous button, step backward
- auto_en  in  1  level; enables auto-scroll
- freeze  in  1  level; inhibits all mode changes
- select  out  2  mux select, registered
- mode_change  out  1  one-cycle pulse, high in the first cycle of a new `select` value
- blank  out  1  high while the blank window is active

## Operation
- Each button passes through a 2-flop synchronizer, then a debouncer.
- Debouncer behaviour:
  - The counter increments each cycle that the synchronized level differs from the debounced state.
  - The counter clears on any cycle where the two are equal.
  - On the DEBOUNCE_CYCLES-th consecutive differing cycle, the debounced state flips and the counter clears.
- Rising edge of a debounced state produces a one-cycle step request (next_req / prev_req). Falling edges produce nothing.
- Step resolution, evaluated per cycle in this priority order:
  - freeze=1: all requests discarded, not queued; dwell counter holds its value.
  - next_req and prev_req both high: no change; both discarded.
  - next_req: select <= select+1, wrapping 3 to 0.
  - prev_req: select <= select-1, wrapping 0 to 3.
  - Otherwise, if auto_en=1 and the dwell counter equals DWELL_CYCLES-1: select <= select+1.
- Dwell counter:
  - Counts only while auto_en=1 and freeze=0.
  - Clears to 0 on any select change (manual or auto).
  - Clears to 0 whenever auto_en=0.
- Blank FSM:
  - States SHOW and BLANK.
  - SHOW to BLANK on any select change; the blank counter loads 0.
  - In BLANK, the counter increments each cycle. At BLANK_CYCLES-1 the FSM returns to SHOW.
  - A new select change while in BLANK restarts the counter and stays in BLANK.
  - blank = (state == BLANK).
- Debouncing and blanking continue while freeze=1. Only step application is inhibited.

## Timing
- Reset values:
  - select=2'b00, mode_change=0, blank=0, state=SHOW.
  - All counters 0, synchronizers 0, debounced states 0.
- Reset mid-blank or mid-debounce aborts immediately. A button still held after reset must be seen released and pressed again to step, because the debounced state starts at 0 and only a rising edge counts.
- Button latency: from the first synchronizer-output-high cycle, the debounced state flips after DEBOUNCE_CYCLES cycles. select updates on the next edge. Total raw-to-select latency is 2 + DEBOUNCE_CYCLES + 1 cycles.
- Auto-scroll: with auto_en held high and no other events, select advances every DWELL_CYCLES cycles exactly.
- mode_change and blank rise in the same cycle that the new select is first visible.
- blank stays high for exactly BLANK_CYCLES cycles after the last change.
- One select change per cycle at most. A manual step in the same cycle as a dwell expiry applies only the manual step.

## Structure
- Shared package display_pkg:
  - typedef enum logic [1:0] display_mode_t: MODE_AVG=2'b00, MODE_VOLT=2'b01, MODE_RAW=2'b10, MODE_SPARE=2'b11.
  - typedef enum logic blank_state_t: SHOW, BLANK.
  - The display mux select is typed display_mode_t.
- Sub-module button_debounce (synchronizer + debouncer + rising-edge pulse, parameter DEBOUNCE_CYCLES), instantiated twice.
- Counter widths are derived with $clog2 of each parameter.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, DWELL_CYCLES=10, BLANK_CYCLES=3.
1. Reset, then press btn_next held 20 cycles.
   - select goes 00 to 01 exactly 7 cycles after the press is applied.
   - mode_change pulses 1 cycle; blank is high 3 cycles.
2. btn_next bouncing: high 3, low 1, high 3, then held.
   - No step until 4 consecutive stable cycles; exactly one step results.
3. Four btn_prev presses from 00.
   - select sequence is 11, 10, 01, 00 (wrap-around).
4. auto_en=1 for 45 cycles from 00.
   - select sequence is 01, 10, 11, 00, at cycles 10, 20, 30, 40.
   - A btn_next press in the same cycle as a dwell expiry gives a single +1 step and restarts dwell.
5. freeze=1 with presses on both buttons and auto_en=1.
   - select is unchanged and no mode_change pulse occurs.
   - Simultaneous next+prev with freeze=0 also gives no change.
6. Second step 1 cycle into a blank window, then reset mid-blank.
   - The second step extends blank to 3 cycles after the second change.
   - Reset drives select=00, blank=0 on the next edge.
